// File: rtl/bandit_pkg.sv
// Shared types and helpers for the epsilon-greedy bandit agent.
package bandit_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_DECIDE,
    ST_SCAN,
    ST_PICK,
    ST_ACT,
    ST_OBSERVE
  } state_e;

  // 8-bit Fibonacci step: shift left, feedback parity of tapped bits into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] state, input logic [7:0] taps);
    return {state[6:0], ^(state & taps)};
  endfunction

  function automatic bit arms_ok(input int unsigned arms);
    return (arms >= 2) && (arms <= 256) && ((arms & (arms - 1)) == 0);
  endfunction

  function automatic bit widths_ok(input int unsigned value_width, input int unsigned reward_width);
    return value_width >= reward_width;
  endfunction

  function automatic bit seed_ok(input logic [7:0] seed);
    return seed != '0;
  endfunction

endpackage

// File: rtl/bandit_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used as the exploration noise source.
module bandit_lfsr
  import bandit_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hff,
  parameter logic [7:0] TAPS = 8'hb1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [7:0] state_o
);

  logic [7:0] state_q, state_d;

  assign state_d = lfsr_next(state_q, TAPS);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SEED;
    else         state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/bandit_egreedy.sv
// Epsilon-greedy multi-armed bandit agent: Q table, argmax scan or random pick,
// constant step-size update from a signed reward.
module bandit_egreedy
  import bandit_pkg::*;
#(
  parameter int unsigned ARMS         = 16,
  parameter int unsigned REWARD_WIDTH = 8,
  parameter int unsigned VALUE_WIDTH  = 16,
  parameter int unsigned ALPHA_SHIFT  = 3,
  parameter logic [8:0]  EPSILON      = 9'd16,
  parameter int          Q_INIT       = 0,
  parameter logic [7:0]  SEED         = 8'hff,
  parameter logic [7:0]  TAPS         = 8'hb1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           explore,
  input  logic                           clear,
  input  logic                           reward_valid,
  input  logic signed [REWARD_WIDTH-1:0] reward_data,
  output logic                           reward_ready,
  output logic                           action_valid,
  output logic [$clog2(ARMS)-1:0]        action_data,
  input  logic                           action_ready,
  output logic                           action_explore
);

  localparam int unsigned             AW   = $clog2(ARMS);
  localparam logic [AW-1:0]           LAST = AW'(ARMS - 1);
  localparam logic signed [VALUE_WIDTH-1:0] QI = VALUE_WIDTH'(Q_INIT);

  if (!arms_ok(ARMS)) begin : g_bad_arms
    $error("bandit_egreedy: ARMS must be a power of two in 2..256");
  end
  if (!widths_ok(VALUE_WIDTH, REWARD_WIDTH)) begin : g_bad_widths
    $error("bandit_egreedy: VALUE_WIDTH must be >= REWARD_WIDTH");
  end
  if (!seed_ok(SEED)) begin : g_bad_seed
    $error("bandit_egreedy: SEED must be non-zero");
  end

  state_e                         state_q, state_d;
  logic [AW-1:0]                  cnt_q, cnt_d;
  logic [AW-1:0]                  best_idx_q, best_idx_d;
  logic signed [VALUE_WIDTH-1:0]  best_val_q, best_val_d;
  logic [AW-1:0]                  action_data_q, action_data_d;
  logic                           action_explore_q, action_explore_d;
  logic                           action_valid_q, action_valid_d;
  logic                           reward_ready_q, reward_ready_d;

  logic signed [VALUE_WIDTH-1:0]  q_table_q [ARMS];
  logic                           tbl_we;
  logic [AW-1:0]                  tbl_waddr;
  logic signed [VALUE_WIDTH-1:0]  tbl_wdata;

  logic [7:0]                     lfsr;
  logic [AW-1:0]                  pick_idx;
  logic signed [VALUE_WIDTH-1:0]  rd_val;
  logic                           scan_take;
  logic signed [VALUE_WIDTH:0]    r_ext, q_ext, diff;
  logic signed [VALUE_WIDTH-1:0]  step, q_upd;

  bandit_lfsr #(
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .state_o (lfsr)
  );

  assign pick_idx  = lfsr[AW-1:0];
  assign rd_val    = q_table_q[cnt_q];
  assign scan_take = (cnt_q == '0) || (rd_val > best_val_q);

  // best_val_q carries the chosen arm's Q from SCAN/PICK into OBSERVE.
  // Q stays between old Q and r, so truncating the step to VALUE_WIDTH is exact.
  assign r_ext = {{(VALUE_WIDTH + 1 - REWARD_WIDTH){reward_data[REWARD_WIDTH-1]}}, reward_data};
  assign q_ext = {best_val_q[VALUE_WIDTH-1], best_val_q};
  assign diff  = r_ext - q_ext;
  assign step  = VALUE_WIDTH'(diff >>> ALPHA_SHIFT);
  assign q_upd = best_val_q + step;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    best_idx_d       = best_idx_q;
    best_val_d       = best_val_q;
    action_data_d    = action_data_q;
    action_explore_d = action_explore_q;
    tbl_we           = 1'b0;
    tbl_waddr        = cnt_q;
    tbl_wdata        = QI;

    unique case (state_q)
      ST_INIT: begin
        tbl_we    = 1'b1;
        tbl_waddr = cnt_q;
        tbl_wdata = QI;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        cnt_d = '0;
        if (explore && ({1'b0, lfsr} < EPSILON)) state_d = ST_PICK;
        else                                      state_d = ST_SCAN;
      end
      ST_PICK: begin
        action_data_d    = pick_idx;
        best_val_d       = q_table_q[pick_idx];
        action_explore_d = 1'b1;
        state_d          = ST_ACT;
      end
      ST_SCAN: begin
        if (scan_take) begin
          best_idx_d = cnt_q;
          best_val_d = rd_val;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d            = '0;
          action_data_d    = scan_take ? cnt_q : best_idx_q;
          action_explore_d = 1'b0;
          state_d          = ST_ACT;
        end
      end
      ST_ACT: begin
        if (action_ready) state_d = ST_OBSERVE;
      end
      ST_OBSERVE: begin
        if (reward_valid) begin
          tbl_we    = 1'b1;
          tbl_waddr = action_data_q;
          tbl_wdata = q_upd;
          state_d   = ST_DECIDE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Clear wins over any handshake in the same cycle and suppresses its write.
    if (clear && (state_q != ST_INIT)) begin
      state_d = ST_INIT;
      cnt_d   = '0;
      tbl_we  = 1'b0;
    end

    action_valid_d = (state_d == ST_ACT);
    reward_ready_d = (state_d == ST_OBSERVE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_INIT;
      cnt_q            <= '0;
      best_idx_q       <= '0;
      best_val_q       <= '0;
      action_data_q    <= '0;
      action_explore_q <= 1'b0;
      action_valid_q   <= 1'b0;
      reward_ready_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      best_idx_q       <= best_idx_d;
      best_val_q       <= best_val_d;
      action_data_q    <= action_data_d;
      action_explore_q <= action_explore_d;
      action_valid_q   <= action_valid_d;
      reward_ready_q   <= reward_ready_d;
    end
  end

  always_ff @(posedge clock) begin
    if (tbl_we) q_table_q[tbl_waddr] <= tbl_wdata;
  end

  assign action_valid   = action_valid_q;
  assign reward_ready   = reward_ready_q;
  assign action_data    = action_data_q;
  assign action_explore = action_explore_q;

endmodule

// File: tb/tb_bandit_egreedy.sv
// Directed self-checking bench for bandit_egreedy with ARMS=4, Q_INIT=0, ALPHA_SHIFT=3.
module tb_bandit_egreedy;

  localparam int ARMS = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              explore;
  logic              clear;
  logic              reward_valid;
  logic signed [7:0] reward_data;
  logic              reward_ready;
  logic              action_valid;
  logic [1:0]        action_data;
  logic              action_ready;
  logic              action_explore;

  int         total = 0;
  int         bad   = 0;
  int         qm [ARMS];
  int         cur;
  logic [7:0] m_lfsr;

  bandit_egreedy #(
    .ARMS         (4),
    .REWARD_WIDTH (8),
    .VALUE_WIDTH  (16),
    .ALPHA_SHIFT  (3),
    .EPSILON      (9'd256),
    .Q_INIT       (0),
    .SEED         (8'hff),
    .TAPS         (8'hb1)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .explore        (explore),
    .clear          (clear),
    .reward_valid   (reward_valid),
    .reward_data    (reward_data),
    .reward_ready   (reward_ready),
    .action_valid   (action_valid),
    .action_data    (action_data),
    .action_ready   (action_ready),
    .action_explore (action_explore)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 8'hff;
    else          m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hb1)};
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_action(output int n);
    n = 0;
    while (action_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Floor division by 8 done without an arithmetic shift.
  function automatic int model_upd(input int q, input int r);
    int d;
    int s;
    d = r - q;
    s = (d >= 0) ? d / 8 : -((-d + 7) / 8);
    return q + s;
  endfunction

  function automatic int argmax();
    int b;
    b = 0;
    for (int i = 1; i < ARMS; i++) if (qm[i] > qm[b]) b = i;
    return b;
  endfunction

  function automatic int tbl(input int i);
    return int'($signed(dut.q_table_q[i]));
  endfunction

  // Action handshake, reward handshake, then count cycles to next action_valid.
  task automatic round(input int arm, input int r, output int lat, output int pick);
    action_ready = 1'b1;
    tick();
    action_ready = 1'b0;
    reward_valid = 1'b1;
    reward_data  = 8'(r);
    tick();
    reward_valid = 1'b0;
    qm[arm] = model_upd(qm[arm], r);
    tick();
    pick = int'(m_lfsr[1:0]);
    lat  = 1;
    while (action_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (action_valid !== 1'b0) begin bad++; $display("FAIL reset_action_valid got=%b want=0", action_valid); end
    total++; if (reward_ready !== 1'b0) begin bad++; $display("FAIL reset_reward_ready got=%b want=0", reward_ready); end
    total++; if (action_data !== 2'd0) begin bad++; $display("FAIL reset_action_data got=%0d want=0", action_data); end
    total++; if (action_explore !== 1'b0) begin bad++; $display("FAIL reset_action_explore got=%b want=0", action_explore); end
    total++; if (dut.lfsr !== 8'hff) begin bad++; $display("FAIL reset_lfsr got=%h want=ff", dut.lfsr); end
  endtask

  task automatic test_first_action();
    int lat;
    explore = 1'b0;
    reset_n = 1'b1;
    wait_action(lat);
    total++; if (lat != 9) begin bad++; $display("FAIL first_latency got=%0d want=9", lat); end
    total++; if (action_data !== 2'd0) begin bad++; $display("FAIL first_arm got=%0d want=0", action_data); end
    total++; if (action_explore !== 1'b0) begin bad++; $display("FAIL first_explore got=%b want=0", action_explore); end
    for (int i = 0; i < ARMS; i++) begin
      qm[i] = 0;
      total++; if (tbl(i) != 0) begin bad++; $display("FAIL init_q%0d got=%0d want=0", i, tbl(i)); end
    end
    cur = 0;
  endtask

  task automatic test_update();
    int lat;
    int pick;
    action_ready = 1'b1;
    tick();
    action_ready = 1'b0;
    total++; if ({action_valid, reward_ready} !== 2'b01) begin bad++; $display("FAIL observe_flags got=%b want=01", {action_valid, reward_ready}); end
    reward_valid = 1'b1;
    reward_data  = 8'sd80;
    tick();
    reward_valid = 1'b0;
    qm[0] = model_upd(qm[0], 80);
    total++; if (tbl(0) != 10) begin bad++; $display("FAIL q0_after_80 got=%0d want=10", tbl(0)); end
    wait_action(lat);
    total++; if (lat != 5) begin bad++; $display("FAIL greedy_latency got=%0d want=5", lat); end
    total++; if (action_data !== 2'd0) begin bad++; $display("FAIL arm_after_80 got=%0d want=0", action_data); end
    round(0, -128, lat, pick);
    total++; if (tbl(0) != -8) begin bad++; $display("FAIL q0_after_m128 got=%0d want=-8", tbl(0)); end
    total++; if (lat != 5) begin bad++; $display("FAIL greedy_latency2 got=%0d want=5", lat); end
    total++; if (action_data !== 2'd1) begin bad++; $display("FAIL arm_after_m128 got=%0d want=1", action_data); end
    total++; if (action_explore !== 1'b0) begin bad++; $display("FAIL greedy_explore_flag got=%b want=0", action_explore); end
    cur = 1;
  endtask

  task automatic test_backpressure();
    int lat;
    int pick;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        reward_valid = 1'b1;
        reward_data  = 8'sd50;
      end
      tick();
      reward_valid = 1'b0;
      total++;
      if ({action_valid, reward_ready, action_data, action_explore} !== {1'b1, 1'b0, 2'd1, 1'b0}) begin
        bad++;
        $display("FAIL backpressure_hold cyc=%0d got=%b want=10010", i,
                 {action_valid, reward_ready, action_data, action_explore});
      end
    end
    for (int i = 0; i < ARMS; i++) begin
      total++; if (tbl(i) != qm[i]) begin bad++; $display("FAIL bp_no_write q%0d got=%0d want=%0d", i, tbl(i), qm[i]); end
    end
    round(1, 8, lat, pick);
    total++; if (tbl(1) != 1) begin bad++; $display("FAIL q1_after_8 got=%0d want=1", tbl(1)); end
    total++; if (lat != 5) begin bad++; $display("FAIL bp_latency got=%0d want=5", lat); end
    total++; if (int'(action_data) != argmax()) begin bad++; $display("FAIL bp_arm got=%0d want=%0d", action_data, argmax()); end
    cur = argmax();
  endtask

  task automatic test_explore();
    int lat;
    int pick;
    int rw [4] = '{100, -50, 127, -128};
    explore = 1'b1;
    for (int k = 0; k < 4; k++) begin
      round(cur, rw[k], lat, pick);
      total++; if (tbl(cur) != qm[cur]) begin bad++; $display("FAIL x_q%0d got=%0d want=%0d", cur, tbl(cur), qm[cur]); end
      total++; if (lat != 2) begin bad++; $display("FAIL x_latency k=%0d got=%0d want=2", k, lat); end
      total++; if (int'(action_data) != pick) begin bad++; $display("FAIL x_arm k=%0d got=%0d want=%0d", k, action_data, pick); end
      total++; if (action_explore !== 1'b1) begin bad++; $display("FAIL x_flag k=%0d got=%b want=1", k, action_explore); end
      cur = pick;
    end
  endtask

  task automatic test_clear();
    int n;
    explore      = 1'b0;
    action_ready = 1'b1;
    tick();
    action_ready = 1'b0;
    clear        = 1'b1;
    reward_valid = 1'b1;
    reward_data  = 8'sd127;
    tick();
    reward_valid = 1'b0;
    total++; if (tbl(cur) != qm[cur]) begin bad++; $display("FAIL clear_no_write got=%0d want=%0d", tbl(cur), qm[cur]); end
    total++; if ({action_valid, reward_ready} !== 2'b00) begin bad++; $display("FAIL clear_flags got=%b want=00", {action_valid, reward_ready}); end
    tick();
    tick();
    clear = 1'b0;
    wait_action(n);
    total++; if (n + 2 != 9) begin bad++; $display("FAIL clear_latency got=%0d want=9", n + 2); end
    for (int i = 0; i < ARMS; i++) begin
      qm[i] = 0;
      total++; if (tbl(i) != 0) begin bad++; $display("FAIL clear_q%0d got=%0d want=0", i, tbl(i)); end
    end
    total++; if (action_data !== 2'd0) begin bad++; $display("FAIL clear_arm got=%0d want=0", action_data); end
    cur = 0;
  endtask

  task automatic test_async_reset();
    int lat;
    int pick;
    explore = 1'b1;
    round(cur, 20, lat, pick);
    total++; if ({action_explore, lat == 2} !== 2'b11) begin bad++; $display("FAIL pre_reset_explore got=%b%0d want=1 lat 2", action_explore, lat); end
    cur          = pick;
    explore      = 1'b0;
    action_ready = 1'b1;
    tick();
    action_ready = 1'b0;
    reward_valid = 1'b1;
    reward_data  = 8'sd0;
    tick();
    reward_valid = 1'b0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (action_valid !== 1'b0) begin bad++; $display("FAIL areset_action_valid got=%b want=0", action_valid); end
    total++; if (reward_ready !== 1'b0) begin bad++; $display("FAIL areset_reward_ready got=%b want=0", reward_ready); end
    total++; if (action_data !== 2'd0) begin bad++; $display("FAIL areset_action_data got=%0d want=0", action_data); end
    total++; if (action_explore !== 1'b0) begin bad++; $display("FAIL areset_action_explore got=%b want=0", action_explore); end
    total++; if (dut.lfsr !== 8'hff) begin bad++; $display("FAIL areset_lfsr got=%h want=ff", dut.lfsr); end
    tick();
    tick();
    reset_n = 1'b1;
    wait_action(lat);
    total++; if (lat != 9) begin bad++; $display("FAIL areset_latency got=%0d want=9", lat); end
    total++; if (action_data !== 2'd0) begin bad++; $display("FAIL areset_arm got=%0d want=0", action_data); end
    total++; if (action_explore !== 1'b0) begin bad++; $display("FAIL areset_flag got=%b want=0", action_explore); end
  endtask

  initial begin
    reset_n      = 1'b1;
    explore      = 1'b0;
    clear        = 1'b0;
    reward_valid = 1'b0;
    reward_data  = '0;
    action_ready = 1'b0;
    #1;
    reset_n = 1'b0;
    test_reset();
    test_first_action();
    test_update();
    test_backpressure();
    test_explore();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
